// File: rtl/pipes_pkg.sv
// ============================================================================
// Module      : pipes (package)
// Description : Shared RV64I types, decoded-op enum, opcode/funct constants
//               and encoder format/state types.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pipes;

  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [5:0] {
    UNKNOWN, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADDIW, SLLIW, SRLIW, SRAIW,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    LI
  } decoded_op_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  // Branch and load/store funct3 codes share these numeric values.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH64, FMT_SH32, FMT_S, FMT_B, FMT_J, FMT_U
  } enc_fmt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_EMIT2} enc_state_t;

  typedef struct packed {
    enc_fmt_t   fmt;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       known;
  } op_info_t;

  function automatic op_info_t op_info(decoded_op_t op);
    op_info_t info;
    info       = '0;
    info.known = 1'b1;
    case (op)
      LUI:                          begin info.fmt = FMT_U;    info.opcode = OP_LUI;    end
      AUIPC:                        begin info.fmt = FMT_U;    info.opcode = OP_AUIPC;  end
      JAL:                          begin info.fmt = FMT_J;    info.opcode = OP_JAL;    end
      JALR:                         begin info.fmt = FMT_I;    info.opcode = OP_JALR;   end
      BEQ, BNE, BLT, BGE, BLTU, BGEU:
                                    begin info.fmt = FMT_B;    info.opcode = OP_BRANCH; end
      LB, LH, LW, LD, LBU, LHU, LWU:
                                    begin info.fmt = FMT_I;    info.opcode = OP_LOAD;   end
      SB, SH, SW, SD:               begin info.fmt = FMT_S;    info.opcode = OP_STORE;  end
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI:
                                    begin info.fmt = FMT_I;    info.opcode = OP_IMM;    end
      SLLI, SRLI, SRAI:             begin info.fmt = FMT_SH64; info.opcode = OP_IMM;    end
      ADDIW:                        begin info.fmt = FMT_I;    info.opcode = OP_IMM32;  end
      SLLIW, SRLIW, SRAIW:          begin info.fmt = FMT_SH32; info.opcode = OP_IMM32;  end
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
                                    begin info.fmt = FMT_R;    info.opcode = OP_REG;    end
      ADDW, SUBW, SLLW, SRLW, SRAW: begin info.fmt = FMT_R;    info.opcode = OP_REG32;  end
      default:                      info.known = 1'b0;
    endcase
    case (op)
      SLL, SLLI, SLLW, SLLIW, BNE, LH, SH:                       info.f3 = F3_SLL;
      SLT, SLTI, LW, SW:                                         info.f3 = F3_SLT;
      SLTU, SLTIU, LD, SD:                                       info.f3 = F3_SLTU;
      XOR, XORI, BLT, LBU:                                       info.f3 = F3_XOR;
      SRL, SRA, SRLI, SRAI, SRLW, SRAW, SRLIW, SRAIW, BGE, LHU:  info.f3 = F3_SR;
      OR, ORI, BLTU, LWU:                                        info.f3 = F3_OR;
      AND, ANDI, BGEU:                                           info.f3 = F3_AND;
      default:                                                   info.f3 = F3_ADD;
    endcase
    if (op inside {SUB, SRA, SUBW, SRAW, SRAI, SRAIW}) info.f7 = F7_ALT;
    return info;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_range_check.sv
// ============================================================================
// Module      : imm_range_check
// Description : Combinational immediate range check and field scatter for
//               each RV64I encoding format.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_range_check
  import pipes::*;
(
  input  enc_fmt_t fmt,
  input  word_t    imm,
  output logic     ok,
  output u32       fields
);

  logic s12, s13, s21, s32;

  assign s12 = (&imm[63:11]) || (~|imm[63:11]);
  assign s13 = (&imm[63:12]) || (~|imm[63:12]);
  assign s21 = (&imm[63:20]) || (~|imm[63:20]);
  assign s32 = (&imm[63:31]) || (~|imm[63:31]);

  always_comb begin
    ok     = 1'b1;
    fields = '0;
    case (fmt)
      FMT_I:    begin ok = s12;           fields = {imm[11:0], 20'b0}; end
      FMT_SH64: begin ok = ~|imm[63:6];   fields = {6'b0, imm[5:0], 20'b0}; end
      FMT_SH32: begin ok = ~|imm[63:5];   fields = {7'b0, imm[4:0], 20'b0}; end
      FMT_S:    begin ok = s12;           fields = {imm[11:5], 13'b0, imm[4:0], 7'b0}; end
      FMT_B:    begin
        ok     = s13 && !imm[0];
        fields = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      end
      FMT_J:    begin
        ok     = s21 && !imm[0];
        fields = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      end
      FMT_U:    begin ok = s32 && (imm[11:0] == 12'b0); fields = {imm[31:12], 12'b0}; end
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : RV64I decoded-op to 32-bit instruction encoder with
//               valid/ready request and output handshakes.
//               ENCODER_LI_EN enables LI pseudo-op expansion.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_encoder
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  decoded_op_t req_op,
  input  creg_addr_t  req_rd,
  input  creg_addr_t  req_rs1,
  input  creg_addr_t  req_rs2,
  input  word_t       req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output u32          out_instr,
  output logic        out_last,
  output logic        err,
  output logic        busy
);

  enc_state_t state_q, state_d;
  logic       out_valid_q, out_valid_d;
  u32         out_instr_q, out_instr_d;
  logic       out_last_q, out_last_d;
  logic       err_q, err_d;

  op_info_t   info;
  enc_fmt_t   chk_fmt;
  logic       imm_ok;
  u32         imm_bits;
  u32         word0;
  logic       legal;
  logic       accept;
  creg_addr_t rd_f, rs1_f, rs2_f;
  logic [6:0] f7_f;

`ifdef ENCODER_LI_EN
  u32          pend_q, pend_d;
  u32          word1;
  logic        two_words;
  logic [19:0] li_hi;
  logic        li_fits32;

  // Rounds the upper part up when the low 12 bits will sign-extend negative.
  assign li_hi     = req_imm[31:12] + {19'b0, req_imm[11]};
  assign li_fits32 = (&req_imm[63:31]) || (~|req_imm[63:31]);
`endif

  assign info      = op_info(req_op);
  assign req_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin : check_fmt
    chk_fmt = info.fmt;
`ifdef ENCODER_LI_EN
    if (req_op == LI) chk_fmt = FMT_I;
`endif
  end

  imm_range_check u_imm_chk (
    .fmt    (chk_fmt),
    .imm    (req_imm),
    .ok     (imm_ok),
    .fields (imm_bits)
  );

  always_comb begin : assemble
    legal = info.known && imm_ok;
    rd_f  = req_rd;
    rs1_f = req_rs1;
    rs2_f = req_rs2;
    f7_f  = '0;
    case (info.fmt)
      FMT_R:        f7_f = info.f7;
      FMT_I:        rs2_f = '0;
      FMT_SH64:     begin rs2_f = '0; f7_f = {info.f7[6:1], 1'b0}; end
      FMT_SH32:     begin rs2_f = '0; f7_f = info.f7; end
      FMT_S, FMT_B: rd_f = '0;
      default:      begin rs1_f = '0; rs2_f = '0; end
    endcase
    word0 = imm_bits | {f7_f, rs2_f, rs1_f, info.f3, rd_f, info.opcode};
`ifdef ENCODER_LI_EN
    two_words = 1'b0;
    word1     = '0;
    if (req_op == LI) begin
      legal = 1'b0;
      if (imm_ok) begin
        word0 = imm_bits | {12'b0, 5'b0, F3_ADD, req_rd, OP_IMM};
        legal = 1'b1;
      end else if (li_fits32) begin
        word0     = {li_hi, req_rd, OP_LUI};
        legal     = 1'b1;
        two_words = (req_imm[11:0] != 12'b0);
        word1     = {req_imm[11:0], req_rd, F3_ADD, req_rd, OP_IMM32};
      end
    end
`endif
  end

  always_comb begin : next_state
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
`ifdef ENCODER_LI_EN
    pend_d      = pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (accept) begin
          if (legal) begin
            out_valid_d = 1'b1;
            out_instr_d = word0;
            out_last_d  = 1'b1;
`ifdef ENCODER_LI_EN
            if (two_words) begin
              out_last_d = 1'b0;
              pend_d     = word1;
              state_d    = ST_EMIT;
            end
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef ENCODER_LI_EN
      ST_EMIT: begin
        if (out_ready) begin
          out_instr_d = pend_q;
          out_last_d  = 1'b1;
          state_d     = ST_EMIT2;
        end
      end
      ST_EMIT2: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef ENCODER_LI_EN
      pend_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
`ifdef ENCODER_LI_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder; LI cases
//               depend on ENCODER_LI_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  decoded_op_t req_op;
  creg_addr_t  req_rd, req_rs1, req_rs2;
  word_t       req_imm;
  logic        out_valid;
  logic        out_ready;
  u32          out_instr;
  logic        out_last;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .err       (err),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one clock edge.
  task automatic drive(input decoded_op_t op, input creg_addr_t rd, input creg_addr_t rs1,
                       input creg_addr_t rs2, input word_t imm);
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL req_ready_at_accept op=%s got=%b exp=1", op.name(), req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    req_op = UNKNOWN; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
    n_cmp++; if (out_last !== 1'b0)   begin n_bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(ADD, 5'd3, 5'd1, 5'd2, 64'd0);
    n_cmp++; if (out_valid !== 1'b1)          begin n_bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_instr !== 32'h002081B3)  begin n_bad++; $display("FAIL add_instr got=%h exp=002081b3", out_instr); end
    n_cmp++; if (out_last !== 1'b1)           begin n_bad++; $display("FAIL add_last got=%b exp=1", out_last); end
    n_cmp++; if (err !== 1'b0)                begin n_bad++; $display("FAIL add_err got=%b exp=0", err); end
    tick();
    n_cmp++; if (out_valid !== 1'b0)          begin n_bad++; $display("FAIL add_drain_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0)               begin n_bad++; $display("FAIL add_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_itype_branch();
    out_ready = 1'b1;
    drive(ADDI, 5'd1, 5'd0, 5'd0, -64'sd1);
    n_cmp++; if (out_instr !== 32'hFFF00093) begin n_bad++; $display("FAIL addi_m1 got=%h exp=fff00093", out_instr); end
    drive(ADDI, 5'd1, 5'd0, 5'd7, 64'd2047);
    n_cmp++; if (out_instr !== 32'h7FF00093) begin n_bad++; $display("FAIL addi_2047 got=%h exp=7ff00093", out_instr); end
    drive(BEQ, 5'd9, 5'd1, 5'd2, 64'd8);
    n_cmp++; if (out_instr !== 32'h00208463) begin n_bad++; $display("FAIL beq_p8 got=%h exp=00208463", out_instr); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(SD, 5'd7, 5'd1, 5'd2, 64'd8);
    n_cmp++; if (out_instr !== 32'h0020B423) begin n_bad++; $display("FAIL b2b_sd got=%h exp=0020b423", out_instr); end
    drive(JAL, 5'd1, 5'd3, 5'd4, 64'd2048);
    n_cmp++; if (out_instr !== 32'h001000EF) begin n_bad++; $display("FAIL b2b_jal got=%h exp=001000ef", out_instr); end
    drive(LUI, 5'd5, 5'd0, 5'd0, 64'h12345000);
    n_cmp++; if (out_instr !== 32'h123452B7) begin n_bad++; $display("FAIL b2b_lui got=%h exp=123452b7", out_instr); end
    drive(SRAI, 5'd1, 5'd2, 5'd0, 64'd3);
    n_cmp++; if (out_instr !== 32'h40315093) begin n_bad++; $display("FAIL b2b_srai got=%h exp=40315093", out_instr); end
    drive(SLLIW, 5'd1, 5'd2, 5'd0, 64'd31);
    n_cmp++; if (out_instr !== 32'h01F1109B) begin n_bad++; $display("FAIL b2b_slliw31 got=%h exp=01f1109b", out_instr); end
    n_cmp++; if (out_valid !== 1'b1)         begin n_bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0)         begin n_bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(ADD, 5'd3, 5'd1, 5'd2, 64'd0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_instr !== 32'h002081B3) begin n_bad++; $display("FAIL stall_instr cyc=%0d got=%h exp=002081b3", i, out_instr); end
      n_cmp++; if (out_last !== 1'b1)          begin n_bad++; $display("FAIL stall_last cyc=%0d got=%b exp=1", i, out_last); end
      n_cmp++; if (req_ready !== 1'b0)         begin n_bad++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      tick();
    end
    out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_valid got=%b exp=1", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    decoded_op_t ops[5];
    word_t       imms[5];
    int          n;
    ops[0] = BEQ;     imms[0] = 64'd7;
    ops[1] = SLLIW;   imms[1] = 64'd32;
    ops[2] = ADDI;    imms[2] = 64'd2048;
    ops[3] = UNKNOWN; imms[3] = 64'd0;
    ops[4] = LI;      imms[4] = 64'h1_0000_0000;
    n = 5;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(ops[i], 5'd1, 5'd2, 5'd3, imms[i]);
      n_cmp++; if (err !== 1'b1)       begin n_bad++; $display("FAIL ill_err op=%s got=%b exp=1", ops[i].name(), err); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_valid op=%s got=%b exp=0", ops[i].name(), out_valid); end
      tick();
      n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL ill_err_pulse op=%s got=%b exp=0", ops[i].name(), err); end
    end
`ifndef ENCODER_LI_EN
    drive(LI, 5'd5, 5'd0, 5'd0, 64'd5);
    n_cmp++; if (err !== 1'b1)       begin n_bad++; $display("FAIL li_off_err got=%b exp=1", err); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL li_off_valid got=%b exp=0", out_valid); end
    tick();
`endif
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(ADD, 5'd3, 5'd1, 5'd2, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rststall_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rststall_busy got=%b exp=0", busy); end
    reset = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rststall_stale got=%b exp=0", out_valid); end
  endtask

`ifdef ENCODER_LI_EN
  task automatic test_li();
    out_ready = 1'b1;
    drive(LI, 5'd5, 5'd0, 5'd0, 64'h12345678);
    n_cmp++; if (out_instr !== 32'h123452B7) begin n_bad++; $display("FAIL li_w0 got=%h exp=123452b7", out_instr); end
    n_cmp++; if (out_last !== 1'b0)          begin n_bad++; $display("FAIL li_w0_last got=%b exp=0", out_last); end
    n_cmp++; if (req_ready !== 1'b0)         begin n_bad++; $display("FAIL li_w0_ready got=%b exp=0", req_ready); end
    tick();
    n_cmp++; if (out_instr !== 32'h6782829B) begin n_bad++; $display("FAIL li_w1 got=%h exp=6782829b", out_instr); end
    n_cmp++; if (out_last !== 1'b1)          begin n_bad++; $display("FAIL li_w1_last got=%b exp=1", out_last); end
    n_cmp++; if (req_ready !== 1'b0)         begin n_bad++; $display("FAIL li_w1_ready got=%b exp=0", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0)         begin n_bad++; $display("FAIL li_done_valid got=%b exp=0", out_valid); end
    n_cmp++; if (req_ready !== 1'b1)         begin n_bad++; $display("FAIL li_done_ready got=%b exp=1", req_ready); end
    drive(LI, 5'd5, 5'd0, 5'd0, -64'sd5);
    n_cmp++; if (out_instr !== 32'hFFB00293) begin n_bad++; $display("FAIL li_small got=%h exp=ffb00293", out_instr); end
    n_cmp++; if (out_last !== 1'b1)          begin n_bad++; $display("FAIL li_small_last got=%b exp=1", out_last); end
    drive(LI, 5'd6, 5'd0, 5'd0, 64'h1000);
    n_cmp++; if (out_instr !== 32'h00001337) begin n_bad++; $display("FAIL li_luionly got=%h exp=00001337", out_instr); end
    n_cmp++; if (out_last !== 1'b1)          begin n_bad++; $display("FAIL li_luionly_last got=%b exp=1", out_last); end
    drive(LI, 5'd5, 5'd0, 5'd0, 64'h800);
    n_cmp++; if (out_instr !== 32'h000012B7) begin n_bad++; $display("FAIL li_round_w0 got=%h exp=000012b7", out_instr); end
    tick();
    n_cmp++; if (out_instr !== 32'h8002829B) begin n_bad++; $display("FAIL li_round_w1 got=%h exp=8002829b", out_instr); end
    tick();
  endtask

  task automatic test_reset_emit2();
    out_ready = 1'b1;
    drive(LI, 5'd5, 5'd0, 5'd0, 64'h12345678);
    tick();
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL rst2_pre_last got=%b exp=1", out_last); end
    reset = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst2_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst2_busy got=%b exp=0", busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst2_ready got=%b exp=1", req_ready); end
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst2_stale got=%b exp=0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_itype_branch();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_stall();
`ifdef ENCODER_LI_EN
    test_li();
    test_reset_emit2();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV64I instruction encoder, the inverse of the fetch-stage decoder. Takes decoded-form requests (op, register indices, 64-bit immediate) over a valid/ready handshake and emits raw 32-bit instruction words over a second valid/ready handshake. Optionally expands the LI pseudo-op into one or two real instructions. It sits in the test/boot path, where it generates instruction streams for instruction memory and self-check benches.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_op` in `decoded_op_t`: operation (same enum the decoder produces).
- `req_rd` in `creg_addr_t`: destination register.
- `req_rs1` in `creg_addr_t`: source register 1.
- `req_rs2` in `creg_addr_t`: source register 2.
- `req_imm` in `word_t`: immediate as a signed byte offset or value, not pre-shifted.
- `out_valid` out 1: `out_instr` valid.
- `out_ready` in 1: consumer takes the word when `out_valid && out_ready`.
- `out_instr` out `u32`: raw instruction.
- `out_last` out 1: this word is the final word of its request.
- `err` out 1: one-cycle pulse on an illegal request.
- `busy` out 1: FSM not IDLE or output register occupied.

## Operation
- FSM states:
  - IDLE.
  - EMIT: word 0 registered.
  - EMIT2: LI second word pending.
- `req_ready` = (state==IDLE) && (!out_valid || out_ready). The request is consumed in the accept cycle.
- Encoding formats:
  - R-type: ADD..AND, ADDW/SUBW/SLLW/SRLW/SRAW. Fields are f7, rs2, rs1, f3, rd, opcode per the RV spec.
  - I-type: ALU ops, loads, JALR.
  - S-type: stores.
  - B-type: branches.
  - J-type: JAL.
  - U-type: LUI, AUIPC.
- Register fields a format does not use are written 0.
- Range checks on `req_imm`; a violation gives `err`, no output word, and the request is still consumed:
  - I, S: 12-bit signed, i.e. `imm[63:11]` all equal.
  - B: 13-bit signed and `imm[0]==0`.
  - J: 21-bit signed and `imm[0]==0`.
  - U: `imm[11:0]==0` and `imm[63:31]` all equal.
  - SLLI/SRLI/SRAI: shamt 0..63.
  - SLLIW/SRLIW/SRAIW: shamt 0..31.
- UNKNOWN op gives `err`.
- `err` asserts the cycle after accept. `err` and `out_valid` never both go high for one request.

## Timing
- Reset values:
  - `out_valid`=0, `out_instr`=0, `out_last`=0, `err`=0, `busy`=0, state=IDLE.
  - `req_ready`=1 in the first cycle after reset.
- Latency: accept in cycle N gives `out_valid`=1 in N+1.
- Throughput: one single-word request per cycle under continuous `out_ready`.
- While `out_valid && !out_ready`:
  - `out_instr` and `out_last` are held stable.
  - `req_ready`=0.
- EMIT2: after word 0 handshakes, word 1 is presented in the next cycle with `out_last`=1. `req_ready`=0 until word 1 handshakes.
- Reset asserted mid-request, including in EMIT2, drops all pending words. The next cycle is the reset state.

## Configuration
- `ENCODER_LI_EN` defined: `req_op==LI` is legal.
  - `imm` fits 12-bit signed: ADDI rd,x0,imm (one word).
  - Else if it fits 32-bit signed: hi = `imm[31:12] + imm[11]`, mod 2^20.
    - `imm[11:0]==0`: LUI rd,hi only.
    - Otherwise LUI rd,hi then ADDIW rd,rd,`imm[11:0]`.
  - Wider immediates give `err`.
- `ENCODER_LI_EN` undefined: LI is treated as UNKNOWN (`err`). EMIT2 and the hi/lo split logic are not compiled.

## Structure
- Opcode, f3 and f7 constants (`OP_*`, `F3_*`) stay in the shared `pipes` package, and this block reuses them.
- Add the `LI` enumerator to `decoded_op_t`, along with `LUI`/`AUIPC` if absent.
- Add an `enc_state_t` typedef for the FSM.
- One sub-module, `imm_range_check`: combinational. It takes the format and imm and returns legal/illegal plus packed immediate fields.

## Test plan
- ADD x3,x1,x2 with `out_ready`=1 -> `out_instr`=0x002081B3, `out_last`=1, one cycle after accept.
- ADDI x1,x0,-1 -> 0xFFF00093. BEQ x1,x2,+8 -> 0x00208463.
- LI x5,0x12345678 with `ENCODER_LI_EN` defined -> the following two words on consecutive cycles, then `req_ready` reasserts:
  - 0x123452B7 (`out_last`=0).
  - 0x6782829B (`out_last`=1).
- `out_ready` held 0 for 3 cycles after ADD -> `out_instr` stable at 0x002081B3, `req_ready`=0 throughout. Handshake on cycle 4.
- Illegal inputs, each giving an `err` pulse and `out_valid`=0:
  - BEQ imm=7 (odd).
  - SLLIW shamt=32.
  - ADDI imm=2048.
  - LI with `ENCODER_LI_EN` undefined.
- Reset asserted while LI word 1 is pending (EMIT2) -> next cycle `out_valid`=0, `busy`=0, `req_ready`=1. No stale word afterwards.
